// File: rtl/close_scheduler.sv
// close_scheduler: round-robin session-close sequencer on one shared countdown timer (optional floor clamp via CLOSE_SCHED_CLAMP_EN)
module close_scheduler #(
  parameter int NUM_SESSIONS = 3,
  parameter int CNT_W = 32,
  parameter int MIN_INTERVAL = 30,
  parameter int ID_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SESSIONS-1:0]       req_valid,
  input  logic [NUM_SESSIONS*CNT_W-1:0] req_interval,
  output logic [NUM_SESSIONS-1:0]       req_ready,
  input  logic [NUM_SESSIONS-1:0]       reopen,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic [CNT_W-1:0]              count,
  output logic                          done_valid,
  output logic [ID_W-1:0]               done_id,
  output logic [NUM_SESSIONS-1:0]       closed_mask,
  output logic                          all_closed,
  output logic [7:0]                    close_count
);
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, win_id;
  logic [CNT_W-1:0] count_q, count_d, sel_interval, eff_interval;
  logic [NUM_SESSIONS-1:0] elig, win_oh, closed_q, closed_d, done_oh;
  logic [7:0] close_count_q;
  logic found, hs, all_closed_q;
  assign elig = req_valid & ~closed_q;
  // Round-robin winner among eligible sessions, searching from the one after the last grant
  always_comb begin
    win_oh = '0;
    win_id = '0;
    found = 1'b0;
    sel_interval = '0;
    for (int k = 1; k <= NUM_SESSIONS; k++)
      for (int j = 0; j < NUM_SESSIONS; j++)
        if (!found && elig[j] && j == (int'(rr_ptr_q) + k) % NUM_SESSIONS) begin
          win_oh[j] = 1'b1;
          win_id = ID_W'(j);
          found = 1'b1;
          sel_interval = req_interval[j*CNT_W +: CNT_W];
        end
  end
`ifdef CLOSE_SCHED_CLAMP_EN
  assign eff_interval = sel_interval < CNT_W'(MIN_INTERVAL) ? CNT_W'(MIN_INTERVAL) : sel_interval;
`else
  assign eff_interval = sel_interval;
`endif
  // One-hot of the session being closed, active only in the DONE cycle
  always_comb begin
    done_oh = '0;
    for (int j = 0; j < NUM_SESSIONS; j++)
      done_oh[j] = state_q == DONE && grant_id_q == ID_W'(j);
  end
  // Timer FSM: grant in IDLE, count down to zero, one DONE cycle
  always_comb begin
    hs = state_q == IDLE && found;
    state_d = state_q;
    count_d = count_q;
    grant_id_d = grant_id_q;
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      state_d = COUNT;
      count_d = eff_interval;
      grant_id_d = win_id;
      rr_ptr_d = win_id;
    end else if (state_q == COUNT) begin
      state_d = count_q == '0 ? DONE : COUNT;
      count_d = count_q == '0 ? count_q : count_q - 1'b1;
    end else if (state_q == DONE)
      state_d = IDLE;
    closed_d = (closed_q & ~reopen) | done_oh;
  end
  // State registers; a completion's set of its closed bit overrides a coincident reopen
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_id_q <= '0;
      rr_ptr_q <= ID_W'(NUM_SESSIONS - 1);
      closed_q <= '0;
      all_closed_q <= 1'b0;
      close_count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q <= rr_ptr_d;
      closed_q <= closed_d;
      all_closed_q <= &closed_q;
      close_count_q <= close_count_q + {7'd0, state_q == DONE};
    end
  end
  assign req_ready = state_q == IDLE ? win_oh : '0;
  assign busy = state_q != IDLE;
  assign grant_id = grant_id_q;
  assign count = count_q;
  assign done_valid = state_q == DONE;
  assign done_id = grant_id_q;
  assign closed_mask = closed_q;
  assign all_closed = all_closed_q;
  assign close_count = close_count_q;
endmodule

// File: tb/tb_close_scheduler.sv
// tb_close_scheduler: randomized scoreboard bench for close_scheduler against a schedule-level model
module tb_close_scheduler;
  localparam int N = 3, W = 32, MINI = 30, IW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, reopen = '0, closed_mask;
  logic [N*W-1:0] req_interval = '0;
  logic busy, done_valid, all_closed;
  logic [IW-1:0] grant_id, done_id;
  logic [W-1:0] count;
  logic [7:0] close_count;
  close_scheduler #(.NUM_SESSIONS(N), .CNT_W(W), .MIN_INTERVAL(MINI), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_interval(req_interval), .req_ready(req_ready),
    .reopen(reopen), .busy(busy), .grant_id(grant_id), .count(count), .done_valid(done_valid),
    .done_id(done_id), .closed_mask(closed_mask), .all_closed(all_closed), .close_count(close_count)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; int id;} hs_t;
  typedef struct {int cyc; int id; int cnt;} dn_t;
  hs_t hsq[$];
  dn_t dq[$];
  int cyc = 0, checks = 0, failures = 0;
  int mclosed = 0, mcount = 0, mrr = N - 1, mtotal = 0, last_done = 0;
  int iv[N];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask
  function automatic int eff(input int v);
`ifdef CLOSE_SCHED_CLAMP_EN
    return v < MINI ? MINI : v;
`else
    return v;
`endif
  endfunction
  task automatic tick();
    logic [N-1:0] h;
    @(negedge clk);
    h = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~h;
  endtask
  task automatic pulse_reopen(input int m);
    reopen = N'(m);
    mclosed = mclosed & ~m;
    tick();
    reopen = '0;
  endtask
  // Schedule the whole batch: round-robin over eligible requests, each close occupying L+3 cycles
  task automatic plan(input int s, output int t_end);
    int t, p, w, l;
    t = cyc;
    p = s & ~mclosed;
    for (int i = 0; i < N; i++) req_interval[i*W +: W] = W'(iv[i]);
    while (p != 0) begin
      w = -1;
      for (int k = 1; k <= N; k++) if (w < 0 && ((p >> ((mrr + k) % N)) & 1) == 1) w = (mrr + k) % N;
      l = eff(iv[w]);
      hsq.push_back('{t, w});
      dq.push_back('{t + l + 2, w, mcount});
      mcount = (mcount + 1) % 256;
      mtotal++;
      mclosed = mclosed | (1 << w);
      mrr = w;
      p = p & ~(1 << w);
      last_done = t + l + 2;
      t = t + l + 3;
    end
    t_end = t;
  endtask
  task automatic batch(input int s, input int maxl);
    int te;
    for (int i = 0; i < N; i++) iv[i] = $urandom_range(0, maxl);
    plan(s, te);
    req_valid = N'(s);
    repeat (2) tick();
    while (cyc < te) tick();
    req_valid = '0;
    tick();
    chk("closed_mask", closed_mask, mclosed);
    chk("all_closed", all_closed, mclosed == (1 << N) - 1);
    chk("close_count", close_count, mcount);
    chk("busy_idle", busy, 0);
    chk("pending_done", dq.size(), 0);
  endtask
  // Monitor: grant pattern every cycle and each completion against the scoreboard
  always @(negedge clk) begin
    logic [N-1:0] er;
    dn_t dn;
    if (!rst) begin
      er = '0;
      if (hsq.size() > 0 && hsq[0].cyc == cyc) begin
        er = N'(1 << hsq[0].id);
        void'(hsq.pop_front());
      end
      chk("req_ready", req_ready, er);
      if (done_valid) begin
        if (dq.size() == 0) chk("unexpected_done", done_valid, 0);
        else begin
          dn = dq.pop_front();
          chk("done_cyc", cyc, dn.cyc);
          chk("done_id", done_id, dn.id);
          chk("count_at_done", close_count, dn.cnt);
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        chk("done_missing", done_valid, 1);
        void'(dq.pop_front());
      end
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end
  initial begin
    int te, c, l, nb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_closed_mask", closed_mask, 0);
    chk("rst_all_closed", all_closed, 0);
    chk("rst_close_count", close_count, 0);
    batch(7, 0);
    pulse_reopen(6);
    batch(7, 3);
    nb = 0;
    while (mtotal < 300 && nb < 3000) begin
      pulse_reopen($urandom_range(0, 7));
      batch($urandom_range(0, 7), 5);
      nb++;
    end
    pulse_reopen(7);
    iv[2] = $urandom_range(0, 4);
    plan(4, te);
    req_valid = 3'b100;
    while (cyc < last_done) tick();
    reopen = 3'b100;
    tick();
    reopen = '0;
    chk("set_beats_reopen", closed_mask[2], 1);
    pulse_reopen(4);
    chk("reopen_clears", closed_mask[2], 0);
    batch(4, 3);
    pulse_reopen(7);
    req_interval[0 +: W] = W'(40);
    l = eff(40);
    req_valid = 3'b001;
    c = cyc;
    hsq.push_back('{c, 0});
    while (cyc < c + l - 9) tick();
    chk("count_before_rst", count, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mclosed = 0;
    mcount = 0;
    mrr = N - 1;
    hsq.delete();
    dq.delete();
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_done_valid", done_valid, 0);
    chk("midrst_closed_mask", closed_mask, 0);
    chk("midrst_close_count", close_count, 0);
    repeat (l) tick();
    batch(3, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
